// File: rtl/param_issue_queue.sv
// rtl/param_issue_queue.sv - parameterised issue queue with tag wakeup and single-issue select
// Ports: clk, rst_n (sync, active-low); disp_* dispatch lanes with all-or-nothing disp_ready;
//        wb_valid/wb_tag wakeup broadcast; iss_* selected entry handshake with iss_ready;
//        flush discards every entry; occupancy is the valid-entry count.
// Build option IQ_AGE_SELECT_EN: oldest eligible entry issues (age matrix); otherwise lowest index.
module param_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = 2,
    parameter int WB_PORTS   = 2,
    parameter int PREG_IDX   = 6,
    parameter int AL_IDX     = 5,
    parameter int PAYLOAD_W  = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [DISPATCH_W-1:0]                disp_valid,
    input  logic [DISPATCH_W-1:0][PREG_IDX-1:0]  disp_src1,
    input  logic [DISPATCH_W-1:0][PREG_IDX-1:0]  disp_src2,
    input  logic [DISPATCH_W-1:0]                disp_src1_rdy,
    input  logic [DISPATCH_W-1:0]                disp_src2_rdy,
    input  logic [DISPATCH_W-1:0][AL_IDX-1:0]    disp_al_id,
    input  logic [DISPATCH_W-1:0][PAYLOAD_W-1:0] disp_payload,
    output logic                                 disp_ready,
    input  logic [WB_PORTS-1:0]                  wb_valid,
    input  logic [WB_PORTS-1:0][PREG_IDX-1:0]    wb_tag,
    output logic                                 iss_valid,
    input  logic                                 iss_ready,
    output logic [PREG_IDX-1:0]                  iss_src1,
    output logic [PREG_IDX-1:0]                  iss_src2,
    output logic [AL_IDX-1:0]                    iss_al_id,
    output logic [PAYLOAD_W-1:0]                 iss_payload,
    input  logic                                 flush,
    output logic [$clog2(DEPTH):0]               occupancy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     rdy1_q;
    logic [DEPTH-1:0]     rdy2_q;
    logic [PREG_IDX-1:0]  src1_q    [DEPTH];
    logic [PREG_IDX-1:0]  src2_q    [DEPTH];
    logic [AL_IDX-1:0]    al_id_q   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];

    logic [DEPTH-1:0]                 elig;
    logic [CNT_W-1:0]                 free_cnt;
    logic [DISPATCH_W-1:0][IDX_W-1:0] lane_slot;
    logic [IDX_W-1:0]                 sel_idx;
    logic                             issue_fire;

    function automatic logic wb_hit(input logic [PREG_IDX-1:0] tag);
        wb_hit = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && (wb_tag[p] == tag)) wb_hit = 1'b1;
        end
    endfunction

    // Walk entries low to high: the n-th free entry found is the slot for lane n.
    // The same walk yields the free count, which never includes a same-cycle issue.
    always_comb begin
        lane_slot = '0;
        free_cnt  = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (!valid_q[e]) begin
                for (int l = 0; l < DISPATCH_W; l++) begin
                    if (free_cnt == CNT_W'(l)) lane_slot[l] = IDX_W'(e);
                end
                free_cnt = free_cnt + CNT_W'(1);
            end
        end
    end

    assign disp_ready = (free_cnt >= CNT_W'(DISPATCH_W));
    assign occupancy  = CNT_W'(DEPTH) - free_cnt;
    assign elig       = valid_q & rdy1_q & rdy2_q;
    assign iss_valid  = |elig;
    assign issue_fire = iss_valid && iss_ready;

`ifdef IQ_AGE_SELECT_EN
    // older_q[j][i] set means entry j was dispatched before entry i.
    logic [DEPTH-1:0][DEPTH-1:0] older_q;
    logic [DEPTH-1:0][DEPTH-1:0] older_d;

    // Lanes are applied in order so a higher lane ends up younger than a lower one:
    // each new entry becomes younger than everything, then clears its own row.
    always_comb begin
        older_d = older_q;
        for (int l = 0; l < DISPATCH_W; l++) begin
            if (disp_ready && disp_valid[l]) begin
                for (int j = 0; j < DEPTH; j++) older_d[j][lane_slot[l]] = 1'b1;
                older_d[lane_slot[l]] = '0;
            end
        end
    end

    always_comb begin
        logic blocked;
        blocked = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (elig[j] && older_q[j][i]) blocked = 1'b1;
            end
            if (elig[i] && !blocked) sel_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            older_q <= '0;
        end else if (!flush) begin
            older_q <= older_d;
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (elig[e]) sel_idx = IDX_W'(e);
        end
    end
`endif

    assign iss_src1    = iss_valid ? src1_q[sel_idx]    : '0;
    assign iss_src2    = iss_valid ? src2_q[sel_idx]    : '0;
    assign iss_al_id   = iss_valid ? al_id_q[sel_idx]   : '0;
    assign iss_payload = iss_valid ? payload_q[sel_idx] : '0;

    // Dispatch targets only free entries and issue only an occupied one, so the
    // three updates below never touch the same entry in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (valid_q[e] && wb_hit(src1_q[e])) rdy1_q[e] <= 1'b1;
                if (valid_q[e] && wb_hit(src2_q[e])) rdy2_q[e] <= 1'b1;
            end
            if (issue_fire) valid_q[sel_idx] <= 1'b0;
            if (disp_ready) begin
                for (int l = 0; l < DISPATCH_W; l++) begin
                    if (disp_valid[l]) begin
                        valid_q[lane_slot[l]]   <= 1'b1;
                        src1_q[lane_slot[l]]    <= disp_src1[l];
                        src2_q[lane_slot[l]]    <= disp_src2[l];
                        rdy1_q[lane_slot[l]]    <= disp_src1_rdy[l] | wb_hit(disp_src1[l]);
                        rdy2_q[lane_slot[l]]    <= disp_src2_rdy[l] | wb_hit(disp_src2[l]);
                        al_id_q[lane_slot[l]]   <= disp_al_id[l];
                        payload_q[lane_slot[l]] <= disp_payload[l];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_param_issue_queue.sv
// tb/tb_param_issue_queue.sv - self-checking bench for param_issue_queue
module tb_param_issue_queue;
    localparam int DEPTH = 8;
    localparam int DW    = 2;
    localparam int WBP   = 2;
    localparam int PI    = 6;
    localparam int AI    = 5;
    localparam int PW    = 64;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [DW-1:0]          disp_valid;
    logic [DW-1:0][PI-1:0]  disp_src1;
    logic [DW-1:0][PI-1:0]  disp_src2;
    logic [DW-1:0]          disp_src1_rdy;
    logic [DW-1:0]          disp_src2_rdy;
    logic [DW-1:0][AI-1:0]  disp_al_id;
    logic [DW-1:0][PW-1:0]  disp_payload;
    logic                   disp_ready;
    logic [WBP-1:0]         wb_valid;
    logic [WBP-1:0][PI-1:0] wb_tag;
    logic                   iss_valid;
    logic                   iss_ready;
    logic [PI-1:0]          iss_src1;
    logic [PI-1:0]          iss_src2;
    logic [AI-1:0]          iss_al_id;
    logic [PW-1:0]          iss_payload;
    logic                   flush;
    logic [$clog2(DEPTH):0] occupancy;

    always #5 clk = ~clk;

    param_issue_queue #(
        .DEPTH(DEPTH), .DISPATCH_W(DW), .WB_PORTS(WBP),
        .PREG_IDX(PI), .AL_IDX(AI), .PAYLOAD_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_src1(disp_src1), .disp_src2(disp_src2),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_al_id(disp_al_id), .disp_payload(disp_payload), .disp_ready(disp_ready),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_al_id(iss_al_id),
        .iss_payload(iss_payload), .flush(flush), .occupancy(occupancy)
    );

    typedef struct {
        logic       rst;
        logic       fl;
        logic [1:0] nd;
        logic       ir;
        logic [3:0] exp_occ;
        logic       exp_iv;
        logic       exp_dr;
    } vec_t;

    vec_t        vecs [16];
    logic [80:0] sb_q [$];
    logic [80:0] exp_rec;
    logic [AI-1:0] first_al;
    logic [AI-1:0] second_al;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          popped;
    logic [AI-1:0] al_cnt;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle();
        rst_n         = 1'b1;
        flush         = 1'b0;
        iss_ready     = 1'b0;
        disp_valid    = '0;
        disp_src1     = '0;
        disp_src2     = '0;
        disp_src1_rdy = '0;
        disp_src2_rdy = '0;
        disp_al_id    = '0;
        disp_payload  = '0;
        wb_valid      = '0;
        wb_tag        = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_lane(input int l, input logic [PI-1:0] s1, input logic r1,
                            input logic [PI-1:0] s2, input logic r2,
                            input logic [AI-1:0] al, input logic [PW-1:0] pl);
        disp_valid[l]    = 1'b1;
        disp_src1[l]     = s1;
        disp_src1_rdy[l] = r1;
        disp_src2[l]     = s2;
        disp_src2_rdy[l] = r2;
        disp_al_id[l]    = al;
        disp_payload[l]  = pl;
    endtask

    initial begin
        // rst, fl, nd, ir -> occupancy, iss_valid, disp_ready after the edge
        vecs[0]  = '{1'b0, 1'b0, 2'd2, 1'b0, 4'd2, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 2'd2, 1'b0, 4'd4, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 1'b0, 4'd6, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'd1, 1'b0, 4'd7, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 2'd2, 1'b0, 4'd7, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'd2, 1'b1, 4'd6, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 2'd2, 1'b1, 4'd7, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 1'b1, 4'd6, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b1, 4'd5, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 2'd2, 1'b1, 4'd0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 2'd2, 1'b0, 4'd2, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'd2, 1'b0, 4'd4, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 2'd2, 1'b0, 4'd6, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 2'd2, 1'b1, 4'd0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 2'd1, 1'b0, 4'd1, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b1};

        do_reset();
        check("reset_occ", 96'(occupancy), 96'd0);
        check("reset_iss_valid", 96'(iss_valid), 96'd0);
        check("reset_disp_ready", 96'(disp_ready), 96'd1);
        check("reset_iss_al_id", 96'(iss_al_id), 96'd0);

        al_cnt = 5'd1;
        for (int i = 0; i < 16; i++) begin
            idle();
            rst_n     = !vecs[i].rst;
            flush     = vecs[i].fl;
            iss_ready = vecs[i].ir;
            for (int l = 0; l < int'(vecs[i].nd); l++) begin
                set_lane(l, PI'(i), 1'b1, PI'(l + 1), 1'b1, al_cnt, PW'(i * 16 + l));
                al_cnt = al_cnt + 5'd1;
            end
            step();
            check($sformatf("row%0d_occ", i), 96'(occupancy), 96'(vecs[i].exp_occ));
            check($sformatf("row%0d_iss_valid", i), 96'(iss_valid), 96'(vecs[i].exp_iv));
            check($sformatf("row%0d_disp_ready", i), 96'(disp_ready), 96'(vecs[i].exp_dr));
        end

        // Scoreboard: fill from empty, hold, then drain in dispatch order.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            idle();
            for (int l = 0; l < DW; l++) begin
                logic [PW-1:0] pl;
                pl = {$urandom, $urandom};
                set_lane(l, PI'(8 + 2 * c + l), 1'b1, PI'(40 + 2 * c + l), 1'b1, AI'(1 + 2 * c + l), pl);
                sb_q.push_back({AI'(1 + 2 * c + l), PI'(8 + 2 * c + l), PI'(40 + 2 * c + l), pl});
            end
            step();
            if (c == 0) check("first_iss_al_id", 96'(iss_al_id), 96'd1);
        end
        idle();
        exp_rec = sb_q[0];
        check("hold_al_id_a", 96'(iss_al_id), 96'(exp_rec[80:76]));
        step();
        check("hold_al_id_b", 96'(iss_al_id), 96'(exp_rec[80:76]));
        iss_ready = 1'b1;
        popped = 0;
        for (int c = 0; c < 20 && sb_q.size() > 0; c++) begin
            if (iss_valid) begin
                exp_rec = sb_q.pop_front();
                check("sb_issue", 96'({iss_al_id, iss_src1, iss_src2, iss_payload}), 96'(exp_rec));
                popped++;
            end
            step();
        end
        check("sb_popped", 96'(popped), 96'd6);
        check("sb_drained", 96'(iss_valid), 96'd0);

        // Wakeup: stored entry woken by wb port 1, dispatching lane woken by wb port 0.
        do_reset();
        idle();
        set_lane(0, 6'd12, 1'b0, 6'd3, 1'b1, 5'd9, 64'hA);
        step();
        check("wk_not_ready", 96'(iss_valid), 96'd0);
        check("wk_occ1", 96'(occupancy), 96'd1);
        idle();
        wb_valid  = 2'b11;
        wb_tag[1] = 6'd12;
        wb_tag[0] = 6'd20;
        set_lane(0, 6'd5, 1'b1, 6'd20, 1'b0, 5'd10, 64'hB);
        #1;
        check("wk_same_cycle", 96'(iss_valid), 96'd0);
        step();
        idle();
        check("wk_woken_valid", 96'(iss_valid), 96'd1);
        check("wk_woken_al", 96'(iss_al_id), 96'd9);
        iss_ready = 1'b1;
        step();
        check("wk_disp_woken_valid", 96'(iss_valid), 96'd1);
        check("wk_disp_woken_al", 96'(iss_al_id), 96'd10);
        step();
        check("wk_empty_valid", 96'(iss_valid), 96'd0);
        check("wk_empty_al", 96'(iss_al_id), 96'd0);
        check("wk_empty_occ", 96'(occupancy), 96'd0);

        // Select policy: A lands in idx3 after B in idx5; both wake together.
`ifdef IQ_AGE_SELECT_EN
        first_al  = 5'd21;
        second_al = 5'd22;
`else
        first_al  = 5'd22;
        second_al = 5'd21;
`endif
        do_reset();
        idle();
        set_lane(0, 6'd40, 1'b0, 6'd1, 1'b1, 5'd1, 64'h1);
        set_lane(1, 6'd40, 1'b0, 6'd1, 1'b1, 5'd2, 64'h2);
        step();
        idle();
        set_lane(0, 6'd40, 1'b0, 6'd1, 1'b1, 5'd3, 64'h3);
        set_lane(1, 6'd1, 1'b1, 6'd1, 1'b1, 5'd4, 64'h4);
        step();
        idle();
        set_lane(0, 6'd1, 1'b1, 6'd1, 1'b1, 5'd5, 64'h5);
        set_lane(1, 6'd30, 1'b0, 6'd1, 1'b1, 5'd21, 64'h21);
        step();
        idle();
        iss_ready = 1'b1;
        step();
        check("age_filler_al", 96'(iss_al_id), 96'd5);
        step();
        check("age_fillers_gone", 96'(iss_valid), 96'd0);
        idle();
        set_lane(0, 6'd30, 1'b0, 6'd1, 1'b1, 5'd22, 64'h22);
        step();
        check("age_occ5", 96'(occupancy), 96'd5);
        idle();
        wb_valid  = 2'b01;
        wb_tag[0] = 6'd30;
        step();
        idle();
        check("age_first", 96'(iss_al_id), 96'(first_al));
        iss_ready = 1'b1;
        step();
        check("age_second_valid", 96'(iss_valid), 96'd1);
        check("age_second", 96'(iss_al_id), 96'(second_al));
        idle();
        flush = 1'b1;
        step();
        check("final_flush_occ", 96'(occupancy), 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
